bloom_row_writer: RTL and testbench

- Insertion side of the time-decaying bucketed Bloom table.
- Owns the bucket/loop timebase and accepts insert requests (row address plus bit index).
- For each request it performs a read-modify-write on the row memory: it ages the stored bloom field to the current stamp, sets the requested bit in the newest bucket, and writes the row back with the current bucket/loop stamp.
- Row format: bloom field [DATA_WIDTH-1:BLOOM_INIT_POS]; bucket stamp [BLOOM_INIT_POS-1:BLOOM_INIT_POS-BITS_SHIFT]; loop stamp [BLOOM_INIT_POS-BITS_SHIFT-1:0].

---
 rtl/bloom_row_writer.sv | 211 +++++++++++++++++++++
 tb/tb_bloom_row_writer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bloom_row_writer.sv
// bloom_row_writer
//   Insertion side of the time-decaying bucketed Bloom table. Owns the
//   bucket/loop timebase and turns each insert request into a
//   read-modify-write of one row.
//   - The stored bloom field is aged to the request's snapshot stamp.
//   - The requested bit is set in the newest bucket.
//   - The row is written back stamped with the snapshot bucket/loop.
//
//   Row layout:
//     [DATA_WIDTH-1:BLOOM_INIT_POS]              bloom field (bucket 0 at LSB, newest at MSB)
//     [BLOOM_INIT_POS-1:BLOOM_INIT_POS-BITS_SHIFT] bucket stamp
//     [LOOP_W-1:0]                               loop stamp
//
//   Handshakes:
//     req_valid/req_ready
//       A request transfers on a rising clk edge where both are high.
//       req_ready is high only while idle.
//     mem_rd_req/mem_rd_ack and mem_wr_req/mem_wr_ack
//       The request and its address/data stay stable until the edge
//       that samples the ack high. The transfer happens on that edge.
//
//   Ports:
//     clk, reset_n                      clock, async active-low reset
//     req_valid/req_ready/req_addr/req_bit   insert request
//     mem_rd_req/mem_rd_addr/mem_rd_ack/mem_rd_data   row read port
//     mem_wr_req/mem_wr_addr/mem_wr_data/mem_wr_ack   row write port
//     done                              pulse in the cycle the write is acked
//     err_stamp                         pulse when the stored stamp is invalid/future
//     cur_bucket, cur_loop              current timebase

module bloom_row_writer #(
  parameter int DATA_WIDTH     = 72,
  parameter int NUM_BUCKETS    = 14,
  parameter int BUCKET_SZ      = 4,
  parameter int BLOOM_INIT_POS = 16,
  parameter int BITS_SHIFT     = $clog2(NUM_BUCKETS),
  parameter int LOOP_W         = BLOOM_INIT_POS - BITS_SHIFT,
  parameter int ADDR_W         = 10,
  parameter int TICK_CYCLES    = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [$clog2(BUCKET_SZ)-1:0] req_bit,
  output logic                         mem_rd_req,
  output logic [ADDR_W-1:0]            mem_rd_addr,
  input  logic                         mem_rd_ack,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data,
  output logic                         mem_wr_req,
  output logic [ADDR_W-1:0]            mem_wr_addr,
  output logic [DATA_WIDTH-1:0]        mem_wr_data,
  input  logic                         mem_wr_ack,
  output logic                         done,
  output logic                         err_stamp,
  output logic [BITS_SHIFT-1:0]        cur_bucket,
  output logic [LOOP_W-1:0]            cur_loop
);

  localparam int BLOOM_W    = DATA_WIDTH - BLOOM_INIT_POS;
  localparam int BIT_W      = $clog2(BUCKET_SZ);
  localparam int TICK_W     = $clog2(TICK_CYCLES);
  localparam int NEWEST_LSB = (NUM_BUCKETS - 1) * BUCKET_SZ;
  localparam int SHIFT_W    = BITS_SHIFT + 1 + BIT_W;

  localparam logic [TICK_W-1:0]     TICK_LAST   = TICK_W'(TICK_CYCLES - 1);
  localparam logic [BITS_SHIFT-1:0] BUCKET_LAST = BITS_SHIFT'(NUM_BUCKETS - 1);
  localparam logic [BITS_SHIFT:0]   NB_E        = (BITS_SHIFT + 1)'(NUM_BUCKETS);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_MERGE, S_WR} state_t;

  state_t state_q, state_d;

  logic [TICK_W-1:0]     tick_cnt;
  logic [ADDR_W-1:0]     addr_q;
  logic [BIT_W-1:0]      bit_q;
  logic [BITS_SHIFT-1:0] snap_bucket;
  logic [LOOP_W-1:0]     snap_loop;
  logic [DATA_WIDTH-1:0] rd_row;
  logic [DATA_WIDTH-1:0] wr_row;

  logic [BITS_SHIFT-1:0] row_bucket;
  logic [LOOP_W-1:0]     row_loop;
  logic [BLOOM_W-1:0]    row_bloom;
  logic [LOOP_W-1:0]     dloop;
  logic [BITS_SHIFT:0]   elapsed;
  logic                  clear_bloom;
  logic                  stamp_bad;
  logic [SHIFT_W-1:0]    shift_amt;
  logic [BLOOM_W-1:0]    aged_bloom;
  logic [BLOOM_W-1:0]    set_mask;
  logic [DATA_WIDTH-1:0] merged_row;

  // Timebase: free-running, independent of the request FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt   <= '0;
      cur_bucket <= '0;
      cur_loop   <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      if (cur_bucket == BUCKET_LAST) begin
        cur_bucket <= '0;
        cur_loop   <= cur_loop + LOOP_W'(1);
      end else begin
        cur_bucket <= cur_bucket + BITS_SHIFT'(1);
      end
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_RD;
      end
      S_RD: begin
        mem_rd_req = 1'b1;
        if (mem_rd_ack) state_d = S_MERGE;
      end
      S_MERGE: state_d = S_WR;
      S_WR: begin
        mem_wr_req = 1'b1;
        if (mem_wr_ack) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The stamp snapshot is taken at accept so the whole transaction ages and
  // stamps against one consistent time even if the timebase moves on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      bit_q       <= '0;
      snap_bucket <= '0;
      snap_loop   <= '0;
      rd_row      <= '0;
      wr_row      <= '0;
    end else begin
      if (state_q == S_IDLE && req_valid) begin
        addr_q      <= req_addr;
        bit_q       <= req_bit;
        snap_bucket <= cur_bucket;
        snap_loop   <= cur_loop;
      end
      if (state_q == S_RD && mem_rd_ack) rd_row <= mem_rd_data;
      if (state_q == S_MERGE) wr_row <= merged_row;
    end
  end

  // Aging: figure out how many buckets have elapsed since the row was last
  // stamped and slide the bloom field down by that many buckets.
  always_comb begin
    row_bucket  = rd_row[BLOOM_INIT_POS-1 -: BITS_SHIFT];
    row_loop    = rd_row[LOOP_W-1:0];
    row_bloom   = rd_row[DATA_WIDTH-1:BLOOM_INIT_POS];
    dloop       = snap_loop - row_loop;
    elapsed     = '0;
    clear_bloom = 1'b0;
    stamp_bad   = 1'b0;

    if ({1'b0, row_bucket} >= NB_E) begin
      clear_bloom = 1'b1;
      stamp_bad   = 1'b1;
    end else if (dloop == '0) begin
      if (row_bucket <= snap_bucket) begin
        elapsed = {1'b0, snap_bucket - row_bucket};
      end else begin
        // Row stamped in the future: keep the data as-is and flag it.
        stamp_bad = 1'b1;
      end
    end else if (dloop == LOOP_W'(1)) begin
      elapsed = NB_E - {1'b0, row_bucket} + {1'b0, snap_bucket};
    end else begin
      clear_bloom = 1'b1;
    end

    if (elapsed >= NB_E) clear_bloom = 1'b1;

    shift_amt  = SHIFT_W'(elapsed) * SHIFT_W'(BUCKET_SZ);
    aged_bloom = clear_bloom ? '0 : (row_bloom >> shift_amt);
    set_mask   = BLOOM_W'(1) << (NEWEST_LSB + 32'(bit_q));
    merged_row = {aged_bloom | set_mask, snap_bucket, snap_loop};
  end

  assign err_stamp   = (state_q == S_MERGE) && stamp_bad;
  assign mem_rd_addr = addr_q;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = wr_row;

endmodule

// File: tb/tb_bloom_row_writer.sv
// Testbench for bloom_row_writer (TICK_CYCLES=2 so every loop is 28 cycles).
// Directed insert scenarios with hand-computed rows, a bench-side timebase
// used to time requests to exact stamps, reset abort and timebase wrap.

module tb_bloom_row_writer;

  localparam int DW   = 72;
  localparam int AW   = 10;
  localparam int TICK = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_bit;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_ack;
  logic [DW-1:0] mem_rd_data;
  logic          mem_wr_req;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_ack;
  logic          done;
  logic          err_stamp;
  logic [3:0]    cur_bucket;
  logic [11:0]   cur_loop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bloom_row_writer #(.TICK_CYCLES(TICK)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_bit(req_bit),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
    .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ack(mem_wr_ack),
    .done(done), .err_stamp(err_stamp), .cur_bucket(cur_bucket), .cur_loop(cur_loop)
  );

  // Reference timebase: used only to know when to fire a request.
  int          m_tick;
  logic [3:0]  m_bucket;
  logic [11:0] m_loop;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_tick <= 0; m_bucket <= 4'd0; m_loop <= 12'd0;
    end else if (m_tick == TICK - 1) begin
      m_tick <= 0;
      if (m_bucket == 4'd13) begin
        m_bucket <= 4'd0; m_loop <= m_loop + 12'd1;
      end else begin
        m_bucket <= m_bucket + 4'd1;
      end
    end else begin
      m_tick <= m_tick + 1;
    end
  end

  function automatic logic [DW-1:0] mk_row(input logic [55:0] bloom, input logic [3:0] b,
                                           input logic [11:0] l);
    return {bloom, b, l};
  endfunction

  // Called at a negedge; returns at the negedge where the stamp starts.
  task automatic wait_stamp(input logic [3:0] b, input logic [11:0] l);
    int c;
    c = 0;
    while (!(m_tick == 0 && m_bucket == b && m_loop == l) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (c >= 2000 || cur_bucket !== b || cur_loop !== l) begin
      n_fail++;
      $display("FAIL timebase_at_stamp: got b=%0d l=%0d want b=%0d l=%0d (waited %0d)",
               cur_bucket, cur_loop, b, l, c);
    end
  endtask

  // Driver + memory responder. Called at a negedge with req_ready high;
  // returns at a negedge one cycle after done. lat counts the accept cycle as 1.
  task automatic do_insert(input logic [AW-1:0] addr, input logic [1:0] bitv,
                           input logic [DW-1:0] row, input int rd_delay,
                           output logic [DW-1:0] wr_data, output logic [AW-1:0] wr_addr,
                           output logic [AW-1:0] rd_addr, output int lat, output int errs,
                           output logic got_done);
    int rd_wait;
    wr_data = '0; wr_addr = '0; rd_addr = '0; lat = 1; errs = 0; got_done = 1'b0; rd_wait = 0;
    req_valid = 1'b1; req_addr = addr; req_bit = bitv;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 64 && !got_done; c++) begin
      lat++;
      mem_rd_ack = 1'b0; mem_wr_ack = 1'b0;
      if (err_stamp) errs++;
      if (mem_rd_req) begin
        rd_addr = mem_rd_addr;
        if (rd_wait >= rd_delay) begin
          mem_rd_ack = 1'b1; mem_rd_data = row;
        end
        rd_wait++;
      end
      if (mem_wr_req) begin
        wr_data = mem_wr_data; wr_addr = mem_wr_addr; mem_wr_ack = 1'b1;
      end
      #1;
      if (done) got_done = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    mem_rd_ack = 1'b0; mem_wr_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_bit = '0;
    mem_rd_ack = 1'b0; mem_rd_data = '0; mem_wr_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req_ready, mem_rd_req, mem_wr_req, done, err_stamp} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 10000",
               {req_ready, mem_rd_req, mem_wr_req, done, err_stamp});
    end
    n_checks++;
    if (mem_rd_addr !== '0 || mem_wr_addr !== '0 || mem_wr_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got rd_addr=%h wr_addr=%h wr_data=%h want 0",
               mem_rd_addr, mem_wr_addr, mem_wr_data);
    end
    n_checks++;
    if (cur_bucket !== 4'd0 || cur_loop !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_time: got b=%0d l=%0d want 0 0", cur_bucket, cur_loop);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic_insert();
    logic [DW-1:0] wd; logic [AW-1:0] wa, ra; int lat, errs; logic gd;
    logic [DW-1:0] exp_row;
    exp_row = 72'h40_0000_0000_0000_0000;
    wait_stamp(4'd0, 12'd0);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_ready: got %b want 1", req_ready);
    end
    do_insert(10'd5, 2'd2, '0, 0, wd, wa, ra, lat, errs, gd);
    n_checks++;
    if (wd !== exp_row) begin
      n_fail++; $display("FAIL basic_wr_data: got %h want %h", wd, exp_row);
    end
    n_checks++;
    if (wa !== 10'd5 || ra !== 10'd5) begin
      n_fail++; $display("FAIL basic_addr: got rd=%0d wr=%0d want 5 5", ra, wa);
    end
    n_checks++;
    if (!gd || lat != 4) begin
      n_fail++; $display("FAIL basic_latency: got done=%b lat=%0d want 1 4", gd, lat);
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++; $display("FAIL basic_err: got %0d want 0", errs);
    end
  endtask

  task automatic test_age_same_loop();
    logic [DW-1:0] wd; logic [AW-1:0] wa, ra; int lat, errs; logic gd;
    logic [DW-1:0] exp_row;
    // elapsed 2 -> bit 52 moves to 44; new bit 52; stamp (5,0)
    exp_row = 72'h10100000000000_5000;
    wait_stamp(4'd5, 12'd0);
    do_insert(10'd17, 2'd0, mk_row(56'h10000000000000, 4'd3, 12'd0), 0,
              wd, wa, ra, lat, errs, gd);
    n_checks++;
    if (wd !== exp_row) begin
      n_fail++; $display("FAIL age_same_loop: got %h want %h", wd, exp_row);
    end
    n_checks++;
    if (errs != 0 || !gd || wa !== 10'd17) begin
      n_fail++;
      $display("FAIL age_same_loop_ctl: got err=%0d done=%b addr=%0d want 0 1 17", errs, gd, wa);
    end
  endtask

  task automatic test_bad_stamps();
    logic [DW-1:0] wd; logic [AW-1:0] wa, ra; int lat, errs; logic gd;
    logic [DW-1:0] exp_row;
    // future bucket in the same loop: data kept unshifted, error flagged
    exp_row = 72'h8123456789ABCD_2004;
    wait_stamp(4'd2, 12'd4);
    do_insert(10'd100, 2'd3, mk_row(56'h0123456789ABCD, 4'd9, 12'd4), 0,
              wd, wa, ra, lat, errs, gd);
    n_checks++;
    if (wd !== exp_row) begin
      n_fail++; $display("FAIL future_stamp_row: got %h want %h", wd, exp_row);
    end
    n_checks++;
    if (errs != 1) begin
      n_fail++; $display("FAIL future_stamp_err: got %0d pulses want 1", errs);
    end
    // bucket stamp 15 is not a valid bucket: cleared and flagged
    exp_row = 72'h20000000000000_6004;
    wait_stamp(4'd6, 12'd4);
    do_insert(10'd101, 2'd1, mk_row(56'hFFFFFFFFFFFFFF, 4'd15, 12'd4), 0,
              wd, wa, ra, lat, errs, gd);
    n_checks++;
    if (wd !== exp_row) begin
      n_fail++; $display("FAIL invalid_bucket_row: got %h want %h", wd, exp_row);
    end
    n_checks++;
    if (errs != 1) begin
      n_fail++; $display("FAIL invalid_bucket_err: got %0d pulses want 1", errs);
    end
  endtask

  task automatic test_prev_loop();
    logic [DW-1:0] wd; logic [AW-1:0] wa, ra; int lat, errs; logic gd;
    logic [DW-1:0] exp_row;
    // (12,7) -> (1,8): elapsed 3, shift 12, then bit 54
    exp_row = 72'h400FEDCBA98765_1008;
    wait_stamp(4'd1, 12'd8);
    do_insert(10'd1023, 2'd2, mk_row(56'hFEDCBA98765432, 4'd12, 12'd7), 0,
              wd, wa, ra, lat, errs, gd);
    n_checks++;
    if (wd !== exp_row) begin
      n_fail++; $display("FAIL prev_loop_age: got %h want %h", wd, exp_row);
    end
    n_checks++;
    if (errs != 0 || wa !== 10'd1023) begin
      n_fail++; $display("FAIL prev_loop_ctl: got err=%0d addr=%0d want 0 1023", errs, wa);
    end
  endtask

  task automatic test_stale_and_edges();
    logic [DW-1:0] wd; logic [AW-1:0] wa, ra; int lat, errs; logic gd;
    logic [DW-1:0] exp_row;
    // two loops old: cleared, no error
    exp_row = 72'h10000000000000_0009;
    wait_stamp(4'd0, 12'd9);
    do_insert(10'd7, 2'd0, mk_row(56'hFFFFFFFFFFFFFF, 4'd3, 12'd7), 0,
              wd, wa, ra, lat, errs, gd);
    n_checks++;
    if (wd !== exp_row || errs != 0) begin
      n_fail++; $display("FAIL stale_loop: got %h err=%0d want %h err=0", wd, errs, exp_row);
    end
    // (4,8) -> (3,9): elapsed 13, only the oldest nibble survives
    exp_row = 72'h1000000000000F_3009;
    wait_stamp(4'd3, 12'd9);
    do_insert(10'd8, 2'd0, mk_row(56'hF0000000000000, 4'd4, 12'd8), 0,
              wd, wa, ra, lat, errs, gd);
    n_checks++;
    if (wd !== exp_row || errs != 0) begin
      n_fail++; $display("FAIL elapsed_13: got %h err=%0d want %h err=0", wd, errs, exp_row);
    end
    // (7,8) -> (7,9): elapsed exactly 14, cleared
    exp_row = 72'h20000000000000_7009;
    wait_stamp(4'd7, 12'd9);
    do_insert(10'd9, 2'd1, mk_row(56'hFFFFFFFFFFFFFF, 4'd7, 12'd8), 0,
              wd, wa, ra, lat, errs, gd);
    n_checks++;
    if (wd !== exp_row || errs != 0) begin
      n_fail++; $display("FAIL elapsed_14: got %h err=%0d want %h err=0", wd, errs, exp_row);
    end
  endtask

  task automatic test_reset_mid_read();
    logic bad;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_ready_before: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_addr = 10'd3; req_bit = 2'd1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (mem_rd_req !== 1'b1 || mem_wr_req !== 1'b0 || done !== 1'b0 || req_ready !== 1'b0)
        bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL abort_hold_rd: got early exit from read wait want steady rd_req");
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || mem_rd_req !== 1'b0 || cur_bucket !== 4'd0 || cur_loop !== 12'd0) begin
      n_fail++;
      $display("FAIL abort_async_reset: got ready=%b rd=%b b=%0d l=%0d want 1 0 0 0",
               req_ready, mem_rd_req, cur_bucket, cur_loop);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || cur_bucket !== 4'd0 || cur_loop !== 12'd0) begin
      n_fail++;
      $display("FAIL abort_release: got ready=%b b=%0d l=%0d want 1 0 0",
               req_ready, cur_bucket, cur_loop);
    end
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_wr_req !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL abort_no_write: got write/done after abort want none");
    end
  endtask

  task automatic test_tick_wrap();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    // 2 cycles per bucket: bucket 13 after 26 edges, wrap on edge 28
    repeat (26) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (cur_bucket !== 4'd13 || cur_loop !== 12'd0) begin
      n_fail++; $display("FAIL wrap_pre: got b=%0d l=%0d want 13 0", cur_bucket, cur_loop);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (cur_bucket !== 4'd13 || cur_loop !== 12'd0) begin
      n_fail++; $display("FAIL wrap_hold: got b=%0d l=%0d want 13 0", cur_bucket, cur_loop);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (cur_bucket !== 4'd0 || cur_loop !== 12'd1) begin
      n_fail++; $display("FAIL wrap_loop_inc: got b=%0d l=%0d want 0 1", cur_bucket, cur_loop);
    end
  endtask

  initial begin
    test_reset();
    test_basic_insert();
    test_age_same_loop();
    test_bad_stamps();
    test_prev_loop();
    test_stale_and_edges();
    test_reset_mid_read();
    test_tick_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
